// File: rtl/wr_mem_burst.sv
// ---------------------------------------------------------------------------
// wr_mem_burst
//   Moves one video line from a first-word-fall-through source FIFO into the
//   MCB write port. A line is made of BRST_NUM bursts of BRST_LEN words. For
//   each burst, the block streams the words into the MCB write-data FIFO and
//   then issues one WRITE command. After the last burst it hands the port
//   back to the arbiter through memcon_donep. Frame buffers are ping-ponged
//   on the rising edge of vs, and this edge is applied only between lines.
//
// Ports
//   memclk, rst          clock and asynchronous active-high reset
//   vs                   vertical sync (pclk domain, synchronised here)
//   memcon_en            arbiter grant
//   memcon_donep         line done, held for 4 cycles
//   arb_state            arbiter state, commands only at 2'b00
//   src_dout/empty/count source FIFO read side
//   src_rd_en            source FIFO pop
//   mcb_wr_*             MCB write-data port
//   mcb_cmd_*            MCB command port
//   wr_frame             frame buffer currently being written
// ---------------------------------------------------------------------------
module wr_mem_burst #(
  parameter int DWIDTH   = 128,
  parameter int BRST_LEN = 60,
  parameter int BRST_NUM = 4,
  parameter int LINES    = 1080
) (
  input  logic                  memclk,
  input  logic                  rst,
  input  logic                  vs,
  input  logic                  memcon_en,
  output logic                  memcon_donep,
  input  logic [1:0]            arb_state,
  input  logic [DWIDTH-1:0]     src_dout,
  input  logic                  src_empty,
  input  logic [6:0]            src_count,
  output logic                  src_rd_en,
  output logic                  mcb_wr_en,
  output logic [DWIDTH-1:0]     mcb_wr_data,
  output logic [DWIDTH/8-1:0]   mcb_wr_mask,
  input  logic                  mcb_wr_full,
  output logic                  mcb_cmd_en,
  output logic [2:0]            mcb_cmd_instr,
  output logic [5:0]            mcb_cmd_bl,
  output logic [29:0]           mcb_cmd_byte_addr,
  input  logic                  mcb_cmd_full,
  output logic                  wr_frame
);

  localparam int BW = (BRST_NUM > 1) ? $clog2(BRST_NUM) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_ISSUE = 3'd2,
    S_CMD   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic            r_vs_s1;
  logic            r_vs_s2;
  logic            r_vs_s3;
  logic            r_pend;
  logic            r_frame;
  logic [10:0]     r_line;
  logic [BW-1:0]   r_burst;
  logic [6:0]      r_wcnt;
  logic [2:0]      r_done_cnt;
  logic            r_cmd_en;
  logic [29:0]     r_addr;

  logic            w_push;
  logic            w_start;
  logic            w_fire;
  logic            w_frame_evt;
  logic            w_next_burst;
  logic            w_done_entry;
  logic            w_src_ok;
  logic            w_vs_rise;
  logic [12:0]     w_offset;

  assign w_vs_rise = r_vs_s2 & ~r_vs_s3;
  assign w_src_ok  = (src_count >= 7'(BRST_LEN));
  // Byte offset of the burst within the line: 16 bytes per MCB word.
  assign w_offset  = 13'(32'(r_burst) * 32'(BRST_LEN) * 32'd16);

  assign src_rd_en         = w_push;
  assign mcb_wr_en         = w_push;
  assign mcb_wr_data       = src_dout;
  assign mcb_wr_mask       = '0;
  assign mcb_cmd_en        = r_cmd_en;
  assign mcb_cmd_instr     = 3'b000;
  assign mcb_cmd_bl        = 6'(BRST_LEN - 1);
  assign mcb_cmd_byte_addr = r_addr;
  assign wr_frame          = r_frame;
  assign memcon_donep      = (r_done_cnt != 3'd0);

  always_ff @(posedge memclk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_push       = 1'b0;
    w_start      = 1'b0;
    w_fire       = 1'b0;
    w_frame_evt  = 1'b0;
    w_next_burst = 1'b0;
    w_done_entry = 1'b0;
    case (r_state)
      S_IDLE: begin
        // A pending frame switch takes priority and costs one idle cycle.
        if (r_pend) begin
          w_frame_evt = 1'b1;
        end else if (memcon_en && !memcon_donep && w_src_ok) begin
          w_state_nxt = S_FILL;
          w_start     = 1'b1;
        end
      end
      S_FILL: begin
        w_push = ~src_empty & ~mcb_wr_full;
        if (w_push && (r_wcnt == 7'(BRST_LEN - 1))) begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!mcb_cmd_full && (arb_state == 2'b00)) begin
          w_fire      = 1'b1;
          w_state_nxt = S_CMD;
        end
      end
      S_CMD: begin
        // Next burst starts only once a whole burst is already buffered, so
        // FILL never starves partway through.
        if (r_burst == BW'(BRST_NUM - 1)) begin
          w_state_nxt  = S_DONE;
          w_done_entry = 1'b1;
        end else if (w_src_ok) begin
          w_state_nxt  = S_FILL;
          w_start      = 1'b1;
          w_next_burst = 1'b1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge memclk or posedge rst) begin
    if (rst) begin
      r_vs_s1    <= 1'b0;
      r_vs_s2    <= 1'b0;
      r_vs_s3    <= 1'b0;
      r_pend     <= 1'b0;
      r_frame    <= 1'b0;
      r_line     <= '0;
      r_burst    <= '0;
      r_wcnt     <= '0;
      r_done_cnt <= '0;
      r_cmd_en   <= 1'b0;
      r_addr     <= '0;
    end else begin
      r_vs_s1  <= vs;
      r_vs_s2  <= r_vs_s1;
      r_vs_s3  <= r_vs_s2;
      r_cmd_en <= w_fire;

      // A new edge wins over the clear so that no vsync is ever dropped.
      if (w_vs_rise) begin
        r_pend <= 1'b1;
      end else if (w_frame_evt) begin
        r_pend <= 1'b0;
      end

      if (w_frame_evt) begin
        r_frame <= ~r_frame;
      end

      if (w_frame_evt) begin
        r_line <= '0;
      end else if (r_state == S_DONE) begin
        r_line <= (r_line == 11'(LINES - 1)) ? 11'd0 : r_line + 11'd1;
      end

      if (r_state == S_DONE) begin
        r_burst <= '0;
      end else if (w_next_burst) begin
        r_burst <= r_burst + BW'(1);
      end

      if (w_start) begin
        r_wcnt <= '0;
      end else if (w_push) begin
        r_wcnt <= r_wcnt + 7'd1;
      end

      if (w_fire) begin
        r_addr <= {5'd0, r_frame, r_line, w_offset};
      end

      if (w_done_entry) begin
        r_done_cnt <= 3'd4;
      end else if (r_done_cnt != 3'd0) begin
        r_done_cnt <= r_done_cnt - 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_wr_mem_burst.sv
module tb_wr_mem_burst;

  localparam int DW = 128;
  localparam int BL = 60;
  localparam int BN = 4;
  localparam int NL = 12;

  logic            memclk = 1'b0;
  logic            rst;
  logic            vs;
  logic            memcon_en;
  logic            memcon_donep;
  logic [1:0]      arb_state;
  logic [DW-1:0]   src_dout;
  logic            src_empty;
  logic [6:0]      src_count;
  logic            src_rd_en;
  logic            mcb_wr_en;
  logic [DW-1:0]   mcb_wr_data;
  logic [DW/8-1:0] mcb_wr_mask;
  logic            mcb_wr_full;
  logic            mcb_cmd_en;
  logic [2:0]      mcb_cmd_instr;
  logic [5:0]      mcb_cmd_bl;
  logic [29:0]     mcb_cmd_byte_addr;
  logic            mcb_cmd_full;
  logic            wr_frame;

  wr_mem_burst #(.DWIDTH(DW), .BRST_LEN(BL), .BRST_NUM(BN), .LINES(NL)) dut (
    .memclk(memclk), .rst(rst), .vs(vs), .memcon_en(memcon_en),
    .memcon_donep(memcon_donep), .arb_state(arb_state), .src_dout(src_dout),
    .src_empty(src_empty), .src_count(src_count), .src_rd_en(src_rd_en),
    .mcb_wr_en(mcb_wr_en), .mcb_wr_data(mcb_wr_data), .mcb_wr_mask(mcb_wr_mask),
    .mcb_wr_full(mcb_wr_full), .mcb_cmd_en(mcb_cmd_en), .mcb_cmd_instr(mcb_cmd_instr),
    .mcb_cmd_bl(mcb_cmd_bl), .mcb_cmd_byte_addr(mcb_cmd_byte_addr),
    .mcb_cmd_full(mcb_cmd_full), .wr_frame(wr_frame)
  );

  always #5 memclk = ~memclk;

  // Source FIFO model: an array of random words read in order.
  logic [DW-1:0] words [0:8191];
  int unsigned   rd_ptr = 0;
  assign src_dout = words[rd_ptr[12:0]];
  always @(posedge memclk) if (src_rd_en === 1'b1) rd_ptr <= rd_ptr + 1;

  // Observation records, written only by the monitor.
  int unsigned exp_idx = 0;
  int          burst_push = 0;
  int          total_push = 0;
  int          push_bad = 0;
  int          cmd_bad = 0;
  int          don_run = 0;
  int          cmd_run = 0;
  logic        prev_issue_ok = 1'b0;
  logic [29:0] cmd_addr_q[$];
  int          cmd_push_q[$];
  int          donep_q[$];

  always @(negedge memclk) begin
    prev_issue_ok <= (arb_state == 2'b00) && (mcb_cmd_full == 1'b0);
    if (rst) begin
      burst_push <= 0;
      don_run    <= 0;
      cmd_run    <= 0;
    end else begin
      if (mcb_wr_en === 1'b1 || src_rd_en === 1'b1) begin
        if (mcb_wr_en !== src_rd_en || src_empty !== 1'b0 || mcb_wr_full !== 1'b0 ||
            memcon_donep !== 1'b0 || mcb_wr_data !== words[exp_idx[12:0]])
          push_bad <= push_bad + 1;
        exp_idx    <= exp_idx + 1;
        total_push <= total_push + 1;
      end
      if (mcb_cmd_en === 1'b1) begin
        if (cmd_run != 0 || !prev_issue_ok) cmd_bad <= cmd_bad + 1;
        cmd_addr_q.push_back(mcb_cmd_byte_addr);
        cmd_push_q.push_back(burst_push);
        burst_push <= 0;
        cmd_run    <= 1;
      end else begin
        cmd_run <= 0;
        if (mcb_wr_en === 1'b1) burst_push <= burst_push + 1;
      end
      if (memcon_donep === 1'b1) begin
        don_run <= don_run + 1;
      end else if (don_run > 0) begin
        donep_q.push_back(don_run);
        don_run <= 0;
      end
    end
  end

  // Backpressure driver: sole writer of the full/empty inputs.
  logic bp_on = 1'b0;
  initial begin
    int bp_cyc;
    bp_cyc = 0;
    src_empty = 1'b0; mcb_wr_full = 1'b0; mcb_cmd_full = 1'b0;
    forever begin
      @(posedge memclk); #1;
      if (bp_on) begin
        bp_cyc++;
        if (bp_cyc % 3 == 0) mcb_wr_full = ~mcb_wr_full;
        src_empty    = ($urandom_range(0, 3) == 0);
        mcb_cmd_full = ($urandom_range(0, 3) == 0);
      end else begin
        src_empty = 1'b0; mcb_wr_full = 1'b0; mcb_cmd_full = 1'b0;
      end
    end
  end

  int   checks = 0;
  int   errors = 0;
  logic m_frame;
  int   m_line;
  logic m_pend;
  int   cmd_rd;
  int   don_rd;
  int   pb0;
  int   cb0;

  task automatic tick(input int n);
    repeat (n) begin @(posedge memclk); #1; end
  endtask

  task automatic do_reset();
    rst = 1'b1; vs = 1'b0; memcon_en = 1'b0; arb_state = 2'b00;
    src_count = 7'd64; bp_on = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(2);
    m_frame = 1'b0; m_line = 0; m_pend = 1'b0;
    cmd_rd = cmd_addr_q.size(); don_rd = donep_q.size();
    pb0 = push_bad; cb0 = cmd_bad;
  endtask

  // Reference: each line is BN commands at frame/line/burst*BL*16 bytes,
  // preceded by exactly BL pushes, followed by a 4-cycle done pulse.
  task automatic run_lines(input int n);
    int target, to, e;
    target = cmd_rd + BN * n;
    to = 0;
    while (cmd_addr_q.size() < target && to < 4000 * n) begin tick(1); to++; end
    memcon_en = 1'b0;
    to = 0;
    while (donep_q.size() < don_rd + n && to < 100) begin tick(1); to++; end
    tick(8);
    checks++;
    if (cmd_addr_q.size() != target || donep_q.size() != don_rd + n) begin
      errors++;
      $display("FAIL line_progress: cmds %0d required %0d, done pulses %0d required %0d",
               cmd_addr_q.size(), target, donep_q.size(), don_rd + n);
      cmd_rd = cmd_addr_q.size(); don_rd = donep_q.size();
    end else begin
      for (int i = 0; i < n; i++) begin
        for (int b = 0; b < BN; b++) begin
          e = (int'(m_frame) << 24) + (m_line << 13) + b * BL * 16;
          checks++;
          if (cmd_addr_q[cmd_rd] !== 30'(e)) begin
            errors++;
            $display("FAIL cmd_addr line %0d burst %0d: got %0d required %0d",
                     m_line, b, cmd_addr_q[cmd_rd], e);
          end
          checks++;
          if (cmd_push_q[cmd_rd] !== BL) begin
            errors++;
            $display("FAIL burst_pushes line %0d burst %0d: got %0d required %0d",
                     m_line, b, cmd_push_q[cmd_rd], BL);
          end
          cmd_rd++;
        end
        checks++;
        if (donep_q[don_rd] !== 4) begin
          errors++;
          $display("FAIL donep_len: got %0d required 4", donep_q[don_rd]);
        end
        don_rd++;
        m_line = (m_line + 1) % NL;
      end
    end
    if (m_pend) begin m_frame = ~m_frame; m_line = 0; m_pend = 1'b0; end
    checks++;
    if (wr_frame !== m_frame) begin
      errors++;
      $display("FAIL wr_frame: got %b required %b", wr_frame, m_frame);
    end
    checks++;
    if (push_bad != pb0) begin
      errors++;
      $display("FAIL push_rules: %0d bad pushes, required 0", push_bad - pb0);
    end
    checks++;
    if (cmd_bad != cb0) begin
      errors++;
      $display("FAIL cmd_rules: %0d bad command strobes, required 0", cmd_bad - cb0);
    end
    pb0 = push_bad; cb0 = cmd_bad;
  endtask

  task automatic test_reset();
    rst = 1'b1; vs = 1'b0; memcon_en = 1'b0; arb_state = 2'b00; src_count = 7'd64;
    tick(2);
    checks++;
    if ({src_rd_en, mcb_wr_en, mcb_cmd_en, memcon_donep, wr_frame} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 00000",
               {src_rd_en, mcb_wr_en, mcb_cmd_en, memcon_donep, wr_frame});
    end
    checks++;
    if (mcb_cmd_byte_addr !== 30'd0) begin
      errors++; $display("FAIL reset_addr: got %0d required 0", mcb_cmd_byte_addr);
    end
    checks++;
    if (mcb_wr_mask !== '0) begin
      errors++; $display("FAIL wr_mask: got %h required 0", mcb_wr_mask);
    end
    checks++;
    if (mcb_cmd_instr !== 3'b000) begin
      errors++; $display("FAIL cmd_instr: got %b required 000", mcb_cmd_instr);
    end
    checks++;
    if (mcb_cmd_bl !== 6'(BL - 1)) begin
      errors++; $display("FAIL cmd_bl: got %0d required %0d", mcb_cmd_bl, BL - 1);
    end
    rst = 1'b0;
    tick(6);
    checks++;
    if ({src_rd_en, mcb_wr_en, mcb_cmd_en, memcon_donep, wr_frame} !== 5'b0) begin
      errors++;
      $display("FAIL idle_no_grant: got %b required 00000",
               {src_rd_en, mcb_wr_en, mcb_cmd_en, memcon_donep, wr_frame});
    end
  endtask

  task automatic test_full_line();
    int t0;
    do_reset();
    t0 = total_push;
    memcon_en = 1'b1;
    run_lines(1);
    checks++;
    if (total_push - t0 !== BN * BL) begin
      errors++;
      $display("FAIL line_pushes: got %0d required %0d", total_push - t0, BN * BL);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    bp_on = 1'b1;
    memcon_en = 1'b1;
    run_lines(2);
    bp_on = 1'b0;
    tick(2);
  endtask

  task automatic test_arb_block();
    int t0, to, n_hi, q0;
    do_reset();
    arb_state = 2'b01;
    t0 = total_push;
    memcon_en = 1'b1;
    to = 0;
    while (total_push - t0 < BL && to < 500) begin tick(1); to++; end
    tick(3);
    q0 = cmd_addr_q.size();
    n_hi = 0;
    for (int i = 0; i < 50; i++) begin
      if (mcb_cmd_en !== 1'b0) n_hi++;
      tick(1);
    end
    checks++;
    if (n_hi != 0 || cmd_addr_q.size() != q0 || total_push - t0 != BL) begin
      errors++;
      $display("FAIL arb_block: cmd_en high %0d cycles, cmds %0d, pushes %0d; required 0, 0, %0d",
               n_hi, cmd_addr_q.size() - q0, total_push - t0, BL);
    end
    arb_state = 2'b00;
    run_lines(1);
  endtask

  task automatic test_frame_line();
    int to;
    do_reset();
    memcon_en = 1'b1;
    run_lines(5);
    memcon_en = 1'b1;
    to = 0;
    while (cmd_addr_q.size() < cmd_rd + 1 && to < 1000) begin tick(1); to++; end
    vs = 1'b1;
    tick(4);
    vs = 1'b0;
    m_pend = 1'b1;
    run_lines(1);
    memcon_en = 1'b1;
    run_lines(NL);
    memcon_en = 1'b1;
    run_lines(1);
  endtask

  task automatic test_reset_mid_fill();
    int t0, to;
    do_reset();
    t0 = total_push;
    memcon_en = 1'b1;
    to = 0;
    while (total_push - t0 < 30 && to < 500) begin tick(1); to++; end
    checks++;
    if (src_rd_en !== 1'b1 || total_push - t0 != 30) begin
      errors++;
      $display("FAIL mid_fill_setup: rd_en %b pushes %0d required 1, 30",
               src_rd_en, total_push - t0);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({src_rd_en, mcb_wr_en, mcb_cmd_en, memcon_donep, wr_frame} !== 5'b0 ||
        mcb_cmd_byte_addr !== 30'd0) begin
      errors++;
      $display("FAIL async_reset: ctrl %b addr %0d required 00000, 0",
               {src_rd_en, mcb_wr_en, mcb_cmd_en, memcon_donep, wr_frame},
               mcb_cmd_byte_addr);
    end
    tick(2);
    rst = 1'b0;
    tick(2);
    m_frame = 1'b0; m_line = 0; m_pend = 1'b0;
    cmd_rd = cmd_addr_q.size(); don_rd = donep_q.size();
    pb0 = push_bad; cb0 = cmd_bad;
    memcon_en = 1'b1;
    run_lines(1);
  endtask

  initial begin
    rst = 1'b1; vs = 1'b0; memcon_en = 1'b0; arb_state = 2'b00; src_count = 7'd64;
    for (int i = 0; i < 8192; i++) words[i] = {$urandom, $urandom, $urandom, $urandom};
    test_reset();
    test_full_line();
    test_backpressure();
    test_arb_block();
    test_frame_line();
    test_reset_mid_fill();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
